// File: rtl/gray_counter_pkg.sv
// Shared types, limits and code conversions for the Gray counter bank.
// GRAY_COUNTER_BANK_BIN_OUT_EN adds a registered binary output per channel.
package gray_counter_pkg;

  localparam int NCH_MIN   = 1;
  localparam int NCH_MAX   = 16;
  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 16;

`ifdef GRAY_COUNTER_BANK_BIN_OUT_EN
  localparam bit BIN_OUT_EN = 1'b1;
`else
  localparam bit BIN_OUT_EN = 1'b0;
`endif

  typedef logic [WIDTH_MAX-1:0] word_t;

  function automatic word_t bin2gray(input word_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic word_t gray2bin(input word_t g);
    word_t b;
    b[WIDTH_MAX-1] = g[WIDTH_MAX-1];
    for (int i = WIDTH_MAX - 2; i >= 0; i--)
      b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/gray_counter_chan.sv
// One Gray counter channel: binary state, registered Gray code and wrap flag.
// GRAY_COUNTER_BANK_BIN_OUT_EN exposes the binary state as o_bin.
module gray_counter_chan
  import gray_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic             i_up,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic [WIDTH-1:0] o_gray,
  output logic             o_wrap
`ifdef GRAY_COUNTER_BANK_BIN_OUT_EN
  ,
  output logic [WIDTH-1:0] o_bin
`endif
);

  localparam logic [WIDTH-1:0] ONES = '1;

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_wrap;
  logic [WIDTH-1:0] w_nxt;
  logic             w_wrap;

  always_comb begin
    w_nxt  = r_bin;
    w_wrap = 1'b0;
    priority case (1'b1)
      i_clr:  w_nxt = '0;
      i_load: w_nxt = i_load_val;
      i_en: begin
        if (i_up) begin
          w_nxt  = r_bin + WIDTH'(1);
          w_wrap = (r_bin == ONES);
        end else begin
          w_nxt  = r_bin - WIDTH'(1);
          w_wrap = (r_bin == '0);
        end
      end
      default: ;
    endcase
  end

  // Gray is encoded from the next state so the output stays a pure flop.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      r_bin  <= '0;
      r_gray <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_bin  <= w_nxt;
      r_gray <= WIDTH'(bin2gray(word_t'(w_nxt)));
      r_wrap <= w_wrap;
    end
  end

  assign o_gray = r_gray;
  assign o_wrap = r_wrap;

`ifdef GRAY_COUNTER_BANK_BIN_OUT_EN
  assign o_bin = r_bin;
`endif

endmodule

// File: rtl/gray_counter_bank.sv
// Bank of NCH independent up/down Gray counters with load, clear and wrap.
// GRAY_COUNTER_BANK_BIN_OUT_EN adds the bin output port.
module gray_counter_bank
  import gray_counter_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCH-1:0]       en,
  input  logic [NCH-1:0]       up,
  input  logic [NCH-1:0]       clr,
  input  logic [NCH-1:0]       load,
  input  logic [NCH*WIDTH-1:0] load_val,
  output logic [NCH*WIDTH-1:0] gray,
  output logic [NCH-1:0]       wrap
`ifdef GRAY_COUNTER_BANK_BIN_OUT_EN
  ,
  output logic [NCH*WIDTH-1:0] bin
`endif
);

  if (NCH < NCH_MIN || NCH > NCH_MAX) begin : g_bad_nch
    $error("gray_counter_bank: NCH out of range");
  end

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("gray_counter_bank: WIDTH out of range");
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    gray_counter_chan #(
      .WIDTH(WIDTH)
    ) u_chan (
      .clk       (clk),
      .i_reset   (reset),
      .i_en      (en[i]),
      .i_up      (up[i]),
      .i_clr     (clr[i]),
      .i_load    (load[i]),
      .i_load_val(load_val[i*WIDTH +: WIDTH]),
      .o_gray    (gray[i*WIDTH +: WIDTH]),
      .o_wrap    (wrap[i])
`ifdef GRAY_COUNTER_BANK_BIN_OUT_EN
      ,
      .o_bin     (bin[i*WIDTH +: WIDTH])
`endif
    );
  end

endmodule

// File: tb/tb_gray_counter_bank.sv
// Directed bench for gray_counter_bank (NCH=2, WIDTH=4).
// Checks bin as well when GRAY_COUNTER_BANK_BIN_OUT_EN is defined.
module tb_gray_counter_bank;

  typedef struct {
    logic [1:0] en;
    logic [1:0] up;
    logic [1:0] clr;
    logic [1:0] load;
    logic [7:0] lv;
    logic [7:0] g;
    logic [1:0] w;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] en = '0;
  logic [1:0] up = '0;
  logic [1:0] clr = '0;
  logic [1:0] load = '0;
  logic [7:0] load_val = '0;
  logic [7:0] gray;
  logic [1:0] wrap;
`ifdef GRAY_COUNTER_BANK_BIN_OUT_EN
  logic [7:0] bin;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  gray_counter_bank #(
    .NCH  (2),
    .WIDTH(4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .up      (up),
    .clr     (clr),
    .load    (load),
    .load_val(load_val),
    .gray    (gray),
    .wrap    (wrap)
`ifdef GRAY_COUNTER_BANK_BIN_OUT_EN
    ,
    .bin     (bin)
`endif
  );

  function automatic logic [3:0] g4(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [3:0] b4(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    b[2] = b[3] ^ g[2];
    b[1] = b[2] ^ g[1];
    b[0] = b[1] ^ g[0];
    return b;
  endfunction

  task automatic chk(input string nm, input logic [7:0] eg,
                     input logic [1:0] ew);
    total++;
    if (gray !== eg || wrap !== ew) begin
      bad++;
      $display("FAIL %s: gray=%b wrap=%b, want gray=%b wrap=%b",
               nm, gray, wrap, eg, ew);
    end
`ifdef GRAY_COUNTER_BANK_BIN_OUT_EN
    total++;
    if (bin !== {b4(gray[7:4]), b4(gray[3:0])}) begin
      bad++;
      $display("FAIL %s bin: got %b, want %b", nm, bin,
               {b4(gray[7:4]), b4(gray[3:0])});
    end
`endif
  endtask

  task automatic drive(input logic [1:0] e, input logic [1:0] u,
                       input logic [1:0] c, input logic [1:0] l,
                       input logic [7:0] v);
    en = e;
    up = u;
    clr = c;
    load = l;
    load_val = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t tv[12];
  logic [3:0] gc[16];

  initial begin
    logic [3:0] m0, m1, n0, n1, p0, p1;
    logic [1:0] ew;
    logic [1:0] r;

    tv[0]  = '{2'b11, 2'b01, 2'b00, 2'b00, 8'h00, 8'b1000_0001, 2'b10};
    tv[1]  = '{2'b11, 2'b01, 2'b00, 2'b00, 8'h00, 8'b1001_0011, 2'b00};
    tv[2]  = '{2'b00, 2'b00, 2'b00, 2'b11, 8'hC5, 8'b1010_0111, 2'b00};
    tv[3]  = '{2'b01, 2'b01, 2'b00, 2'b01, 8'h09, 8'b1010_1101, 2'b00};
    tv[4]  = '{2'b00, 2'b00, 2'b11, 2'b01, 8'h03, 8'b0000_0000, 2'b00};
    tv[5]  = '{2'b01, 2'b00, 2'b00, 2'b10, 8'hF0, 8'b1000_1000, 2'b01};
    tv[6]  = '{2'b11, 2'b11, 2'b00, 2'b00, 8'h00, 8'b0000_0000, 2'b11};
    tv[7]  = '{2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 8'b0000_0000, 2'b00};
    tv[8]  = '{2'b11, 2'b01, 2'b00, 2'b00, 8'h00, 8'b1000_0001, 2'b10};
    tv[9]  = '{2'b11, 2'b10, 2'b00, 2'b00, 8'h00, 8'b0000_0000, 2'b10};
    tv[10] = '{2'b11, 2'b01, 2'b10, 2'b01, 8'h0F, 8'b0000_1000, 2'b00};
    tv[11] = '{2'b01, 2'b01, 2'b01, 2'b00, 8'h00, 8'b0000_0000, 2'b00};

    gc = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101,
           4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010,
           4'b1011, 4'b1001, 4'b1000, 4'b0000};

    #12;
    chk("reset", 8'h00, 2'b00);
    reset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      drive(tv[i].en, tv[i].up, tv[i].clr, tv[i].load, tv[i].lv);
      step();
      chk($sformatf("vec%0d", i), tv[i].g, tv[i].w);
    end

    // ch1 parked at 12 while ch0 runs a full upward lap
    drive(2'b00, 2'b00, 2'b00, 2'b10, 8'hC0);
    step();
    chk("park1", 8'b1010_0000, 2'b00);
    drive(2'b01, 2'b01, 2'b00, 2'b00, 8'h00);
    for (int i = 0; i < 16; i++) begin
      step();
      chk($sformatf("up%0d", i), {4'b1010, gc[i]},
          {1'b0, (i == 15)});
    end

    drive(2'b00, 2'b00, 2'b00, 2'b01, 8'h09);
    step();
    chk("pre_rst", 8'b1010_1101, 2'b00);
    drive(2'b00, 2'b00, 2'b00, 2'b00, 8'h00);
    #2 reset = 1'b0;
    #1 chk("async_rst", 8'h00, 2'b00);
    #1;
    reset = 1'b1;
    drive(2'b01, 2'b01, 2'b00, 2'b00, 8'h00);
    step();
    chk("post_rst", 8'b0000_0001, 2'b00);

    m0 = 4'd1;
    m1 = 4'd0;
    for (int i = 0; i < 48; i++) begin
      r = 2'($urandom_range(0, 3));
      drive(2'b11, r, 2'b00, 2'b00, 8'h00);
      n0 = r[0] ? m0 + 4'd1 : m0 - 4'd1;
      n1 = r[1] ? m1 + 4'd1 : m1 - 4'd1;
      ew[0] = r[0] ? (m0 == 4'hF) : (m0 == 4'h0);
      ew[1] = r[1] ? (m1 == 4'hF) : (m1 == 4'h0);
      p0 = gray[3:0];
      p1 = gray[7:4];
      step();
      chk($sformatf("rnd%0d", i), {g4(n1), g4(n0)}, ew);
      total++;
      if ($countones(p0 ^ gray[3:0]) != 1 ||
          $countones(p1 ^ gray[7:4]) != 1) begin
        bad++;
        $display("FAIL hamming%0d: prev=%b%b now=%b, want 1-bit steps",
                 i, p1, p0, gray);
      end
      m0 = n0;
      m1 = n1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
